dmdr_mb: RTL and testbench
==========================

Name: dmdr_mb

Overview:
- Parametrised multi-beat data memory data register for the image downsampling processor.
- Sits between the byte-wide data memory and the datapath.
- Loads a full word straight from the datapath, assembles 1..MAX_BEATS memory bytes into one word (zero- or sign-extended), or serialises the held word back to memory byte by byte with a valid/ready handshake.
- Supersedes the single-byte data register.

Parameters:
- DATA_W, 19: width of the held word / datapath.
- MEM_W, 8: memory data width (one beat).
- MAX_BEATS, 3: maximum beats per transfer; must equal ceil(DATA_W/MEM_W).
- BEAT_W, 2: width of beat-count inputs; must hold MAX_BEATS.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- RST, in, 1: reset, synchronous, active-high.
- data_wr_en, in, 1: load data_in into the register.
- data_in, in, DATA_W: word from the datapath.
- ld_start, in, 1: start a memory load.
- ld_beats, in, BEAT_W: beats to load.
- ld_sign, in, 1: 1 = sign-extend the assembled word, 0 = zero-extend.
- mem_rvalid, in, 1: memory read byte valid this cycle.
- mem_rdata, in, MEM_W: memory read byte.
- st_start, in, 1: start a store of data_out.
- st_beats, in, BEAT_W: beats to store.
- mem_wvalid, out, 1: store byte valid.
- mem_wdata, out, MEM_W: store byte.
- mem_wready, in, 1: memory accepts the store byte.
- data_out, out, DATA_W: held word.
- busy, out, 1: high in LOAD or STORE.
- done, out, 1: one-cycle pulse when a load or store completes.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-transfer):
  - State goes to IDLE.
  - data_out, shadow accumulator and beat counter are cleared to 0.
  - mem_wvalid, mem_wdata, busy and done are 0.
  - RST has top priority.
- FSM states:
  - IDLE: busy=0.
  - LOAD: busy=1.
  - STORE: busy=1.
- IDLE priority: data_wr_en > ld_start > st_start. Only the highest asserted request acts; the others are dropped, not queued.
- data_wr_en in IDLE: data_out <= data_in next edge; no done pulse. data_wr_en, ld_start and st_start are ignored while busy.
- Beat count: ld_beats/st_beats are sampled at start. A value of 0 is treated as 1; a value above MAX_BEATS is clamped to MAX_BEATS.
- LOAD:
  - Each cycle with mem_rvalid=1 writes mem_rdata into shadow[k*MEM_W +: MEM_W], truncated at DATA_W; k counts from 0 (little-endian), then k increments.
  - mem_rvalid=0 cycles stall with no effect.
  - mem_rvalid in IDLE or STORE is ignored. mem_rvalid on the start edge itself is not captured; the first beat is taken on the following cycle.
  - Completion: the edge after the cycle the last beat is accepted:
    - data_out <= shadow with bits at and above N*MEM_W filled with 0, or with shadow bit N*MEM_W-1 when ld_sign=1.
    - done=1 for that one cycle; state returns to IDLE.
  - Latency: last mem_rvalid in cycle t gives data_out and done visible in cycle t+1.
  - data_out holds its old value throughout the LOAD.
- STORE:
  - The cycle after start, mem_wvalid=1 and mem_wdata = data_out[k*MEM_W +: MEM_W], with bits above DATA_W-1 padded with 0.
  - A beat transfers when mem_wvalid & mem_wready; then k advances.
  - mem_wdata is stable while mem_wvalid=1 and mem_wready=0.
  - After the last transfer: mem_wvalid=0, done=1 in the next cycle, state returns to IDLE.
  - data_out is unchanged by a STORE.
- done never overlaps busy=1 of a new operation. A new start accepted in the same cycle that done is high is legal.
- Beat counter width is BEAT_W; it never wraps past MAX_BEATS-1.

Decomposition:
- Shared package/header dmdr_pkg:
  - State encoding constants: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_STORE=2'd2.
  - Beat-clamp function.
  - Default width constants DATA_W=19, MEM_W=8.
- One sub-module, dmdr_beat_cnt:
  - Clamped beat counter with load, increment and a last-beat flag.
  - Shared by the LOAD and STORE paths.

Test Plan:
- RST=1, then data_wr_en=1 with data_in=19'h5A5A5 -> data_out=19'h5A5A5 next cycle; busy=0, done=0.
- ld_start, ld_beats=1, ld_sign=0, then mem_rvalid with 8'hF3 -> data_out=19'h000F3 and done pulse one cycle after the byte.
- ld_start, ld_beats=2, ld_sign=1, bytes 8'h34, idle gap, 8'h92 -> data_out=19'h79234; done once; busy high throughout.
- ld_beats=3 with bytes 8'h01, 8'h02, 8'hFF -> data_out=19'h70201 (truncated at bit 18).
- data_out=19'h4ABCD, st_start with st_beats=3, mem_wready low for 2 cycles then high -> mem_wdata sequence 8'hCD, 8'hAB, 8'h04, held stable while stalled; done after the third beat; data_out unchanged.
- Mid-load RST after one beat, and simultaneous data_wr_en+ld_start in IDLE -> after RST: IDLE, data_out=0, no done. Simultaneous case: data_in is loaded and the load is dropped. ld_beats=0 -> behaves as 1 beat.

Source files
------------

// File: rtl/dmdr_pkg.sv
// Shared definitions for the multi-beat data memory data register:
// default widths, FSM state encoding and the beat-count clamp.
package dmdr_pkg;

    localparam int DMDR_DATA_W    = 19;
    localparam int DMDR_MEM_W     = 8;
    localparam int DMDR_MAX_BEATS = 3;
    localparam int DMDR_BEAT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // A request of zero beats still moves one beat; oversize requests saturate.
    function automatic int clamp_beats(input int req, input int max_beats);
        if (req < 1)
            return 1;
        else if (req > max_beats)
            return max_beats;
        return req;
    endfunction

endpackage

// File: rtl/dmdr_beat_cnt.sv
// Beat index counter shared by the load and store paths; holds the clamped
// final index of the current transfer and flags when the last beat is current.
module dmdr_beat_cnt
    import dmdr_pkg::*;
#(
    parameter int BEAT_W    = DMDR_BEAT_W,
    parameter int MAX_BEATS = DMDR_MAX_BEATS
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              load,
    input  logic [BEAT_W-1:0] beats,
    input  logic              inc,
    output logic [BEAT_W-1:0] cnt,
    output logic [BEAT_W-1:0] last_idx,
    output logic              last
);

    assign last = (cnt == last_idx);

    // Increment stops at the final index so the count never runs past the transfer.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt      <= '0;
            last_idx <= '0;
        end else if (load) begin
            cnt      <= '0;
            last_idx <= BEAT_W'(clamp_beats(int'(beats), MAX_BEATS) - 1);
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmdr_mb.sv
// Multi-beat data register: direct word load from the datapath, byte-wise
// load assembly with zero/sign extension, and byte-wise store with handshake.
module dmdr_mb
    import dmdr_pkg::*;
#(
    parameter int DATA_W    = DMDR_DATA_W,
    parameter int MEM_W     = DMDR_MEM_W,
    parameter int MAX_BEATS = DMDR_MAX_BEATS,
    parameter int BEAT_W    = DMDR_BEAT_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              data_wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ld_start,
    input  logic [BEAT_W-1:0] ld_beats,
    input  logic              ld_sign,
    input  logic              mem_rvalid,
    input  logic [MEM_W-1:0]  mem_rdata,
    input  logic              st_start,
    input  logic [BEAT_W-1:0] st_beats,
    output logic              mem_wvalid,
    output logic [MEM_W-1:0]  mem_wdata,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int PAD_W = MAX_BEATS * MEM_W;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shadow;
    logic                ld_sign_q;
    logic [BEAT_W-1:0]   cnt, last_idx;
    logic                last;
    logic                ld_go, st_go, beat_acc;
    logic [PAD_W-1:0]    load_pad, store_pad;
    logic [DATA_W-1:0]   load_word;
    int                  fill_bound;

    // A direct word write in IDLE outranks both transfer starts.
    assign ld_go    = (state == ST_IDLE) && !data_wr_en && ld_start;
    assign st_go    = (state == ST_IDLE) && !data_wr_en && !ld_start && st_start;
    assign beat_acc = ((state == ST_LOAD) && mem_rvalid) ||
                      ((state == ST_STORE) && mem_wready);

    dmdr_beat_cnt #(
        .BEAT_W    (BEAT_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_beat_cnt (
        .clk      (clk),
        .RST      (RST),
        .load     (ld_go || st_go),
        .beats    (ld_start ? ld_beats : st_beats),
        .inc      (beat_acc),
        .cnt      (cnt),
        .last_idx (last_idx),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != ST_IDLE);
        mem_wvalid = (state == ST_STORE);
        case (state)
            ST_IDLE: begin
                if (ld_go)
                    state_nxt = ST_LOAD;
                else if (st_go)
                    state_nxt = ST_STORE;
            end
            ST_LOAD, ST_STORE: begin
                if (beat_acc && last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Merge the incoming byte with the shadow, then extend above the last beat.
    always_comb begin
        load_pad   = PAD_W'(shadow);
        load_pad[int'(cnt)*MEM_W +: MEM_W] = mem_rdata;
        fill_bound = (int'(last_idx) + 1) * MEM_W;
        load_word  = load_pad[DATA_W-1:0];
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= fill_bound)
                load_word[i] = ld_sign_q & load_pad[fill_bound-1];
        end
    end

    assign store_pad = PAD_W'(data_out);
    assign mem_wdata = mem_wvalid ? store_pad[int'(cnt)*MEM_W +: MEM_W] : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            data_out  <= '0;
            shadow    <= '0;
            ld_sign_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == ST_IDLE) && data_wr_en)
                data_out <= data_in;
            if (ld_go) begin
                ld_sign_q <= ld_sign;
                shadow    <= '0;
            end
            if ((state == ST_LOAD) && mem_rvalid) begin
                shadow <= load_pad[DATA_W-1:0];
                if (last) begin
                    data_out <= load_word;
                    done     <= 1'b1;
                end
            end
            if ((state == ST_STORE) && mem_wready && last)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmdr_mb.sv
// Directed bench for dmdr_mb: word write, 1/2/3-beat loads, stalled store,
// mid-load reset, request priority and back-to-back transfers.
module tb_dmdr_mb;

    logic        clk;
    logic        RST;
    logic        data_wr_en;
    logic [18:0] data_in;
    logic        ld_start;
    logic [1:0]  ld_beats;
    logic        ld_sign;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        st_start;
    logic [1:0]  st_beats;
    logic        mem_wvalid;
    logic [7:0]  mem_wdata;
    logic        mem_wready;
    logic [18:0] data_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    dmdr_mb dut (
        .clk        (clk),
        .RST        (RST),
        .data_wr_en (data_wr_en),
        .data_in    (data_in),
        .ld_start   (ld_start),
        .ld_beats   (ld_beats),
        .ld_sign    (ld_sign),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .st_start   (st_start),
        .st_beats   (st_beats),
        .mem_wvalid (mem_wvalid),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        total++; if (data_out !== 19'h0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=%h", data_out, 19'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        total++; if (mem_wvalid !== 1'b0 || mem_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wr got=%b/%h exp=0/00", mem_wvalid, mem_wdata); end
        RST = 1'b0;
    endtask

    task automatic test_word_write();
        data_wr_en = 1'b1;
        data_in    = 19'h5A5A5;
        step();
        data_wr_en = 1'b0;
        total++; if (data_out !== 19'h5A5A5) begin bad++; $display("[TB] FAIL wr_data got=%h exp=%h", data_out, 19'h5A5A5); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL wr_flags got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_load_1beat();
        ld_start = 1'b1; ld_beats = 2'd1; ld_sign = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'hEE;
        step();
        ld_start = 1'b0;
        mem_rdata = 8'hF3;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL ld1_start got=%b%b exp=10", busy, done); end
        step();
        mem_rvalid = 1'b0;
        total++; if (data_out !== 19'h000F3) begin bad++; $display("[TB] FAIL ld1_data got=%h exp=%h", data_out, 19'h000F3); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ld1_done got=%b%b exp=10", done, busy); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL ld1_pulse got=%b exp=0", done); end
    endtask

    task automatic test_load_2beat_sign();
        int done_cnt = 0;
        ld_start = 1'b1; ld_beats = 2'd2; ld_sign = 1'b1;
        step();
        ld_start = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'h34;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ld2_busy0 got=%b exp=1", busy); end
        step();
        mem_rvalid = 1'b0;
        if (done) done_cnt++;
        total++; if (busy !== 1'b1 || data_out !== 19'h000F3) begin bad++; $display("[TB] FAIL ld2_beat1 got=%b/%h exp=1/%h", busy, data_out, 19'h000F3); end
        step();
        mem_rvalid = 1'b1; mem_rdata = 8'h92;
        if (done) done_cnt++;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ld2_gap got=%b exp=1", busy); end
        step();
        mem_rvalid = 1'b0;
        if (done) done_cnt++;
        total++; if (data_out !== 19'h79234) begin bad++; $display("[TB] FAIL ld2_data got=%h exp=%h", data_out, 19'h79234); end
        step();
        if (done) done_cnt++;
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL ld2_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_load_3beat_trunc();
        logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'hFF};
        ld_start = 1'b1; ld_beats = 2'd3; ld_sign = 1'b0;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = bytes[i];
            step();
        end
        mem_rvalid = 1'b0;
        total++; if (data_out !== 19'h70201) begin bad++; $display("[TB] FAIL ld3_data got=%h exp=%h", data_out, 19'h70201); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ld3_done got=%b%b exp=10", done, busy); end
        step();
    endtask

    task automatic test_store_stall();
        logic [7:0] exp_bytes [5] = '{8'hCD, 8'hCD, 8'hCD, 8'hAB, 8'h04};
        data_wr_en = 1'b1; data_in = 19'h4ABCD;
        step();
        data_wr_en = 1'b0;
        st_start = 1'b1; st_beats = 2'd3; mem_wready = 1'b0;
        step();
        st_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (mem_wvalid !== 1'b1 || mem_wdata !== exp_bytes[i] || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL st_beat%0d got=%b/%h/%b exp=1/%h/0", i, mem_wvalid, mem_wdata, done, exp_bytes[i]);
            end
            mem_wready = (i >= 2);
            step();
        end
        mem_wready = 1'b0;
        total++; if (mem_wvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL st_end got=%b%b%b exp=010", mem_wvalid, done, busy); end
        total++; if (data_out !== 19'h4ABCD) begin bad++; $display("[TB] FAIL st_data got=%h exp=%h", data_out, 19'h4ABCD); end
        step();
    endtask

    task automatic test_reset_midload();
        ld_start = 1'b1; ld_beats = 2'd3; ld_sign = 1'b0;
        step();
        ld_start = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'h11;
        step();
        mem_rvalid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || data_out !== 19'h0) begin bad++; $display("[TB] FAIL midrst got=%b%b/%h exp=00/00000", busy, done, data_out); end
        mem_rvalid = 1'b1; mem_rdata = 8'h22;
        step();
        step();
        mem_rvalid = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || data_out !== 19'h0) begin bad++; $display("[TB] FAIL midrst_idle got=%b%b/%h exp=00/00000", busy, done, data_out); end
    endtask

    task automatic test_priority();
        data_wr_en = 1'b1; ld_start = 1'b1; ld_beats = 2'd1; data_in = 19'h12345;
        step();
        data_wr_en = 1'b0; ld_start = 1'b0;
        total++; if (data_out !== 19'h12345 || busy !== 1'b0) begin bad++; $display("[TB] FAIL prio_wr got=%h/%b exp=12345/0", data_out, busy); end
        mem_rvalid = 1'b1; mem_rdata = 8'hAA;
        step();
        mem_rvalid = 1'b0;
        total++; if (data_out !== 19'h12345 || done !== 1'b0) begin bad++; $display("[TB] FAIL prio_drop got=%h/%b exp=12345/0", data_out, done); end
    endtask

    task automatic test_back_to_back();
        ld_start = 1'b1; ld_beats = 2'd0; ld_sign = 1'b1;
        step();
        ld_start = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'h80;
        step();
        mem_rvalid = 1'b0;
        total++; if (data_out !== 19'h7FF80 || done !== 1'b1) begin bad++; $display("[TB] FAIL zero_beats got=%h/%b exp=7ff80/1", data_out, done); end
        st_start = 1'b1; st_beats = 2'd0; mem_wready = 1'b1;
        step();
        st_start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || mem_wdata !== 8'h80) begin bad++; $display("[TB] FAIL b2b_store got=%b%b/%h exp=10/80", busy, done, mem_wdata); end
        step();
        mem_wready = 1'b0;
        total++; if (done !== 1'b1 || mem_wvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done got=%b%b%b exp=100", done, mem_wvalid, busy); end
        step();
    endtask

    initial begin
        RST = 1'b1; data_wr_en = 1'b0; data_in = '0; ld_start = 1'b0; ld_beats = '0;
        ld_sign = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; st_start = 1'b0;
        st_beats = '0; mem_wready = 1'b0;
        test_reset();
        test_word_write();
        test_load_1beat();
        test_load_2beat_sign();
        test_load_3beat_trunc();
        test_store_stall();
        test_reset_midload();
        test_priority();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
